// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: shared state encoding and sizing helper for the sequential comparator.
package cmp_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
    function automatic int pair_idx_w(input int width);
        return ($clog2(width / 2) > 1) ? $clog2(width / 2) : 1;
    endfunction
endpackage

// File: rtl/cmp2_cell.sv
// cmp2_cell: combinational 2-bit unsigned magnitude comparator.
module cmp2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       more,
    output logic       less
);
    assign more = a > b;
    assign less = a < b;
endmodule

// File: rtl/compare_seq.sv
// compare_seq: compares two WIDTH-bit operands two bits per cycle, MSB pair first,
// through one shared cmp2_cell, with start/busy/done handshake and held results.
module compare_seq
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             more,
    output logic             less,
    output logic             equal
);
    localparam int IW = pair_idx_w(WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH / 2 - 1);

    cmp_state_t state, nxt;
    logic [WIDTH-1:0] opa, opb;
    logic [IW-1:0] idx;
    logic [1:0] pair_a, pair_b;
    logic cell_more, cell_less, diff, last, finish;
    logic decided, dec_more, dec_less;

    assign pair_a = opa[2*idx +: 2];
    assign pair_b = opb[2*idx +: 2];

    cmp2_cell u_cell (
        .a    (pair_a),
        .b    (pair_b),
        .more (cell_more),
        .less (cell_less)
    );

    assign diff   = cell_more | cell_less;
    assign last   = idx == '0;
    assign finish = EARLY_EXIT ? (diff | last) : last;
    assign busy   = state == RUN;
    assign done   = state == DONE;

    always_comb begin
        nxt = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (finish ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // The first differing pair decides; with EARLY_EXIT it also ends the scan,
    // so decided is never set before finish and one result path serves both modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            idx      <= '0;
            decided  <= 1'b0;
            dec_more <= 1'b0;
            dec_less <= 1'b0;
            more     <= 1'b0;
            less     <= 1'b0;
            equal    <= 1'b0;
        end else if (state == IDLE && start) begin
            opa      <= a;
            opb      <= b;
            idx      <= TOP_IDX;
            decided  <= 1'b0;
            dec_more <= 1'b0;
            dec_less <= 1'b0;
            more     <= 1'b0;
            less     <= 1'b0;
            equal    <= 1'b0;
        end else if (state == RUN) begin
            if (!finish) idx <= idx - 1'b1;
            if (!decided && diff) begin
                decided  <= 1'b1;
                dec_more <= cell_more;
                dec_less <= cell_less;
            end
            if (finish) begin
                more  <= decided ? dec_more : cell_more;
                less  <= decided ? dec_less : cell_less;
                equal <= !decided && !diff;
            end
        end
    end
endmodule

// File: tb/tb_compare_seq.sv
// tb_compare_seq: directed checks of compare_seq over WIDTH=8/4 and both EARLY_EXIT modes.
module tb_compare_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st[4];
    logic [7:0] av_a[4];
    logic [7:0] bv_a[4];
    logic busy[4], done[4], more[4], less[4], equal[4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    compare_seq #(.WIDTH(8), .EARLY_EXIT(1'b1)) d0 (.clk(clk), .rst(rst), .start(st[0]), .a(av_a[0]), .b(bv_a[0]),
        .busy(busy[0]), .done(done[0]), .more(more[0]), .less(less[0]), .equal(equal[0]));
    compare_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) d1 (.clk(clk), .rst(rst), .start(st[1]), .a(av_a[1]), .b(bv_a[1]),
        .busy(busy[1]), .done(done[1]), .more(more[1]), .less(less[1]), .equal(equal[1]));
    compare_seq #(.WIDTH(4), .EARLY_EXIT(1'b1)) d2 (.clk(clk), .rst(rst), .start(st[2]), .a(av_a[2][3:0]), .b(bv_a[2][3:0]),
        .busy(busy[2]), .done(done[2]), .more(more[2]), .less(less[2]), .equal(equal[2]));
    compare_seq #(.WIDTH(4), .EARLY_EXIT(1'b0)) d3 (.clk(clk), .rst(rst), .start(st[3]), .a(av_a[3][3:0]), .b(bv_a[3][3:0]),
        .busy(busy[3]), .done(done[3]), .more(more[3]), .less(less[3]), .equal(equal[3]));

    // Runs one operation; lat = cycles from accept edge to the done cycle (k+1), bc = busy cycles.
    task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output int bc, output logic [2:0] res);
        @(negedge clk);
        st[d] = 1'b1;
        av_a[d] = av;
        bv_a[d] = bv;
        @(negedge clk);
        st[d] = 1'b0;
        av_a[d] = ~av;
        bv_a[d] = ~bv;
        lat = -1;
        bc = 0;
        res = 3'bxxx;
        for (int c = 1; c <= 40; c++) begin
            if (busy[d]) bc++;
            if (done[d]) begin
                lat = c;
                res = {more[d], less[d], equal[d]};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if ({busy[d], done[d], more[d], less[d], equal[d]} !== 5'b0) begin
                bad++;
                $display("FAIL reset dut%0d got=%b want=00000", d, {busy[d], done[d], more[d], less[d], equal[d]});
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_early_more;
        int lat, bc;
        logic [2:0] res;
        do_op(0, 8'hA5, 8'h35, lat, bc, res);
        total++;
        if (lat !== 2 || bc !== 1 || res !== 3'b100) begin
            bad++;
            $display("FAIL early_more lat=%0d busy=%0d res=%b want lat=2 busy=1 res=100", lat, bc, res);
        end
        @(negedge clk);
        total++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0 || {more[0], less[0], equal[0]} !== 3'b100) begin
            bad++;
            $display("FAIL done_pulse done=%b busy=%b res=%b want 0 0 100", done[0], busy[0], {more[0], less[0], equal[0]});
        end
    endtask

    task automatic test_early_less;
        int lat, bc;
        logic [2:0] res;
        do_op(0, 8'h34, 8'h36, lat, bc, res);
        total++;
        if (lat !== 5 || bc !== 4 || res !== 3'b010) begin
            bad++;
            $display("FAIL early_less lat=%0d busy=%0d res=%b want lat=5 busy=4 res=010", lat, bc, res);
        end
    endtask

    task automatic test_equal_hold;
        int lat, bc, got;
        logic [2:0] res;
        for (int d = 0; d < 2; d++) begin
            do_op(d, 8'h5A, 8'h5A, lat, bc, res);
            total++;
            if (lat !== 5 || bc !== 4 || res !== 3'b001) begin
                bad++;
                $display("FAIL equal dut%0d lat=%0d busy=%0d res=%b want lat=5 busy=4 res=001", d, lat, bc, res);
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({done[1], more[1], less[1], equal[1]} !== 4'b0001) begin
                bad++;
                $display("FAIL equal_hold cycle %0d got=%b want=0001", i, {done[1], more[1], less[1], equal[1]});
            end
        end
        st[1] = 1'b1;
        av_a[1] = 8'h35;
        bv_a[1] = 8'hA5;
        @(negedge clk);
        st[1] = 1'b0;
        total++;
        if ({busy[1], more[1], less[1], equal[1]} !== 4'b1000) begin
            bad++;
            $display("FAIL clear_on_start got=%b want=1000", {busy[1], more[1], less[1], equal[1]});
        end
        got = 0;
        for (int c = 0; c < 10 && !done[1]; c++) @(negedge clk);
        if (done[1]) got = {more[1], less[1], equal[1]};
        total++;
        if (got !== 3'b010) begin
            bad++;
            $display("FAIL after_clear res=%b want=010", got[2:0]);
        end
    endtask

    task automatic test_full_scan;
        int lat, bc;
        logic [2:0] res;
        do_op(1, 8'hC0, 8'h40, lat, bc, res);
        total++;
        if (lat !== 5 || bc !== 4 || res !== 3'b100) begin
            bad++;
            $display("FAIL full_scan lat=%0d busy=%0d res=%b want lat=5 busy=4 res=100", lat, bc, res);
        end
        do_op(0, 8'hC0, 8'h40, lat, bc, res);
        total++;
        if (lat !== 2 || res !== 3'b100) begin
            bad++;
            $display("FAIL early_c0 lat=%0d res=%b want lat=2 res=100", lat, res);
        end
    endtask

    // start held high, operands churning: accepts at edges 0, 3, 9; done seen after edges 1, 7, 13.
    task automatic test_back_to_back;
        logic [7:0] ta, tb;
        logic exp_done;
        logic [2:0] exp_res;
        @(negedge clk);
        for (int e = 0; e < 16; e++) begin
            ta = e[0] ? 8'hFF : 8'h00;
            tb = ~ta;
            if (e == 0) begin ta = 8'hA5; tb = 8'h35; end
            if (e == 3) begin ta = 8'h34; tb = 8'h36; end
            if (e == 9) begin ta = 8'h5A; tb = 8'h5A; end
            st[0] = e <= 9;
            av_a[0] = ta;
            bv_a[0] = tb;
            @(negedge clk);
            exp_done = e == 1 || e == 7 || e == 13;
            exp_res = e == 1 ? 3'b100 : e == 7 ? 3'b010 : 3'b001;
            total++;
            if (done[0] !== exp_done || (exp_done && {more[0], less[0], equal[0]} !== exp_res)) begin
                bad++;
                $display("FAIL back_to_back edge %0d done=%b res=%b want done=%b res=%b",
                         e, done[0], {more[0], less[0], equal[0]}, exp_done, exp_res);
            end
        end
        st[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, dones;
        logic [2:0] res;
        @(negedge clk);
        st[0] = 1'b1;
        av_a[0] = 8'h34;
        bv_a[0] = 8'h36;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset busy=%b want=1", busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy[0], done[0], more[0], less[0], equal[0]} !== 5'b0) begin
            bad++;
            $display("FAIL mid_run_reset got=%b want=00000", {busy[0], done[0], more[0], less[0], equal[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done[0] || busy[0]) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL post_reset_activity got=%0d want=0", dones);
        end
        do_op(0, 8'hA5, 8'h35, lat, bc, res);
        total++;
        if (lat !== 2 || bc !== 1 || res !== 3'b100) begin
            bad++;
            $display("FAIL after_reset lat=%0d busy=%0d res=%b want lat=2 busy=1 res=100", lat, bc, res);
        end
    endtask

    task automatic test_exhaustive_w4;
        int lat, bc, k;
        logic [2:0] res, er;
        logic [3:0] xa, ya;
        for (int d = 2; d < 4; d++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    xa = 4'(x);
                    ya = 4'(y);
                    k = (d == 2 && xa[3:2] != ya[3:2]) ? 1 : 2;
                    er = {xa > ya, xa < ya, xa == ya};
                    do_op(d, {4'h0, xa}, {4'h0, ya}, lat, bc, res);
                    total++;
                    if (lat !== k + 1 || bc !== k || res !== er) begin
                        bad++;
                        $display("FAIL w4 dut%0d a=%h b=%h lat=%0d busy=%0d res=%b want lat=%0d busy=%0d res=%b",
                                 d, xa, ya, lat, bc, res, k + 1, k, er);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            st[d] = 1'b0;
            av_a[d] = 8'h00;
            bv_a[d] = 8'h00;
        end
        test_reset;
        test_early_more;
        test_early_less;
        test_equal_hold;
        test_full_scan;
        test_back_to_back;
        test_reset_mid_run;
        test_exhaustive_w4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
